// File: rtl/sprite_draw_sched.sv
// Frame-start driven sprite blitter: drains the draw queue, walks each 32x32 sprite
// with power-of-two replication, clips to the screen and skips transparent pixels.
module sprite_draw_sched #(
    parameter int FB_W             = 320,
    parameter int FB_H             = 240,
    parameter int FB_ADDR_W        = 17,
    parameter int SPRITE_ADDR_SIZE = 13
) (
    input  logic                        sys_clock,
    input  logic                        sys_reset_n,
    input  logic                        frame_start,
    input  logic                        is_empty,
    input  logic [7:0]                  sprite_id,
    input  logic [15:0]                 sprite_x,
    input  logic [15:0]                 sprite_y,
    input  logic [7:0]                  sprite_scale,
    output logic                        dequeue,
    output logic                        sprite_r_en,
    output logic [SPRITE_ADDR_SIZE:0]   sprite_r_addr,
    input  logic [3:0]                  sprite_r_data,
    output logic                        fb_w_en,
    output logic [FB_ADDR_W-1:0]        fb_w_addr,
    output logic [3:0]                  fb_w_data,
    input  logic                        fb_w_ready,
    output logic                        busy,
    output logic                        frame_done,
    output logic [2:0]                  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state;
    logic [3:0]  id_q;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [1:0]  s_q;
    logic [7:0]  dx;
    logic [7:0]  dy;

    logic [7:0]           span_m1;
    logic [4:0]           src_col;
    logic [4:0]           src_row;
    logic [16:0]          x_pos;
    logic [16:0]          y_pos;
    logic                 col_clip;
    logic                 row_clip;
    logic                 in_range;
    logic [FB_ADDR_W-1:0] lin_addr;
    logic                 unused_bits;

    assign unused_bits = ^{sprite_id[7:4], sprite_scale[7:2]};

    always_comb begin
        span_m1 = 8'd31;
        case (s_q)
            2'd0: span_m1 = 8'd31;
            2'd1: span_m1 = 8'd63;
            2'd2: span_m1 = 8'd127;
            2'd3: span_m1 = 8'd255;
            default: span_m1 = 8'd31;
        endcase
    end

    // Replication: every destination step maps back to source pixel (d >> s).
    assign src_col  = 5'(dx >> s_q);
    assign src_row  = 5'(dy >> s_q);
    assign x_pos    = {1'b0, x_q} + 17'(dx);
    assign y_pos    = {1'b0, y_q} + 17'(dy);
    assign col_clip = (x_pos + 17'd1) >= 17'(FB_W);
    assign row_clip = (y_pos + 17'd1) >= 17'(FB_H);
    assign in_range = (x_pos < 17'(FB_W)) && (y_pos < 17'(FB_H));
    assign lin_addr = FB_ADDR_W'(34'(y_pos) * 34'(FB_W) + 34'(x_pos));

    assign sprite_r_addr = (SPRITE_ADDR_SIZE+1)'({id_q, src_row, src_col});

    // Handshakes: dequeue pops the head in the cycle it is high (only when
    // !is_empty); a framebuffer write completes on any cycle with fb_w_en and
    // fb_w_ready both high, and addr/data stay frozen until then.
    assign dequeue     = (state == S_POP) && !is_empty;
    assign sprite_r_en = (state == S_READ);
    assign fb_w_en     = (state == S_WRITE);
    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_DONE);
    assign fsm_state   = state;

    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state     <= S_IDLE;
            id_q      <= 4'd0;
            x_q       <= 16'd0;
            y_q       <= 16'd0;
            s_q       <= 2'd0;
            dx        <= 8'd0;
            dy        <= 8'd0;
            fb_w_addr <= '0;
            fb_w_data <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) state <= S_POP;
                end
                S_POP: begin
                    if (is_empty) begin
                        state <= S_DONE;
                    end else begin
                        id_q <= sprite_id[3:0];
                        x_q  <= sprite_x;
                        y_q  <= sprite_y;
                        s_q  <= sprite_scale[1:0];
                        dx   <= 8'd0;
                        dy   <= 8'd0;
                        // Entirely off-screen origins are consumed without any reads.
                        if (sprite_x >= 16'(FB_W) || sprite_y >= 16'(FB_H))
                            state <= S_POP;
                        else
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sprite_r_data != 4'd0 && in_range) begin
                        fb_w_addr <= lin_addr;
                        fb_w_data <= sprite_r_data;
                        state     <= S_WRITE;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    if (fb_w_ready) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (dx == span_m1 || col_clip) begin
                        dx <= 8'd0;
                        dy <= dy + 8'd1;
                        if (dy == span_m1 || row_clip)
                            state <= S_POP;
                        else
                            state <= S_READ;
                    end else begin
                        dx    <= dx + 8'd1;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_sched.sv
// Scoreboard bench for sprite_draw_sched: a behavioural draw queue and sprite memory
// feed the DUT; expected reads/writes are queued per draw and checked by a monitor.
module tb_sprite_draw_sched;

    logic        sys_clock = 1'b0;
    logic        sys_reset_n;
    logic        frame_start;
    logic        is_empty;
    logic [7:0]  sprite_id;
    logic [15:0] sprite_x;
    logic [15:0] sprite_y;
    logic [7:0]  sprite_scale;
    logic        dequeue;
    logic        sprite_r_en;
    logic [13:0] sprite_r_addr;
    logic [3:0]  sprite_r_data = 4'd0;
    logic        fb_w_en;
    logic [16:0] fb_w_addr;
    logic [3:0]  fb_w_data;
    logic        fb_w_ready;
    logic        busy;
    logic        frame_done;
    logic [2:0]  fsm_state;

    always #5 sys_clock = ~sys_clock;

    sprite_draw_sched #(
        .FB_W(320), .FB_H(240), .FB_ADDR_W(17), .SPRITE_ADDR_SIZE(13)
    ) dut (
        .sys_clock(sys_clock), .sys_reset_n(sys_reset_n), .frame_start(frame_start),
        .is_empty(is_empty), .sprite_id(sprite_id), .sprite_x(sprite_x),
        .sprite_y(sprite_y), .sprite_scale(sprite_scale), .dequeue(dequeue),
        .sprite_r_en(sprite_r_en), .sprite_r_addr(sprite_r_addr),
        .sprite_r_data(sprite_r_data), .fb_w_en(fb_w_en), .fb_w_addr(fb_w_addr),
        .fb_w_data(fb_w_data), .fb_w_ready(fb_w_ready), .busy(busy),
        .frame_done(frame_done), .fsm_state(fsm_state)
    );

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];
    logic [13:0] exp_rd_q[$];

    logic [7:0]  q_id [0:15];
    logic [15:0] q_x  [0:15];
    logic [15:0] q_y  [0:15];
    logic [7:0]  q_sc [0:15];
    int q_head = 0;
    int q_tail = 0;

    int  pat_mode = 0;
    bit  bp_en = 1'b0;
    int  rd_cnt = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    bit  hold_valid = 1'b0;
    logic [16:0] hold_addr;
    logic [3:0]  hold_data;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pix(input logic [13:0] a);
        logic [4:0] r;
        logic [4:0] c;
        r = a[9:5];
        c = a[4:0];
        if (pat_mode == 0) return 4'((r + c) & 5'd15);
        return 4'd5;
    endfunction

    // Behavioural draw queue: head advances on every dequeue.
    always @(posedge sys_clock) if (dequeue) q_head <= q_head + 1;
    assign is_empty     = (q_head == q_tail);
    assign sprite_id    = q_id[q_head[3:0]];
    assign sprite_x     = q_x[q_head[3:0]];
    assign sprite_y     = q_y[q_head[3:0]];
    assign sprite_scale = q_sc[q_head[3:0]];

    // Sprite memory: one-cycle read latency.
    always @(posedge sys_clock) if (sprite_r_en) sprite_r_data <= pix(sprite_r_addr);

    initial begin
        fb_w_ready = 1'b1;
        forever begin
            @(posedge sys_clock);
            #1;
            fb_w_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a read or an accepted write.
    always @(negedge sys_clock) begin
        if (!sys_reset_n) begin
            hold_valid = 1'b0;
        end else begin
            if (dequeue && is_empty) chk("dequeue_when_empty", 1, 0);
            if (frame_done) done_cnt++;
            if (sprite_r_en) begin
                rd_cnt++;
                if (exp_rd_q.size() == 0) chk("rd_unexpected", sprite_r_addr, 0);
                else chk("rd_addr", sprite_r_addr, exp_rd_q.pop_front());
            end
            if (fb_w_en) begin
                if (fb_w_addr >= 17'd76800) chk("wr_addr_range", fb_w_addr, 76799);
                if (hold_valid) chk("wr_hold", {fb_w_addr, fb_w_data}, {hold_addr, hold_data});
                if (fb_w_ready) begin
                    wr_cnt++;
                    hold_valid = 1'b0;
                    if (exp_q.size() == 0) chk("wr_unexpected", {fb_w_addr, fb_w_data}, 0);
                    else chk("wr_addr_data", {fb_w_addr, fb_w_data}, exp_q.pop_front());
                end else begin
                    hold_valid = 1'b1;
                    hold_addr  = fb_w_addr;
                    hold_data  = fb_w_data;
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    // Queue an entry and push the reads/writes a correct scheduler must produce.
    task automatic add_draw(input logic [7:0] id, input int x, input int y, input logic [7:0] sc);
        int s;
        int span;
        logic [13:0] ra;
        logic [3:0] p;
        q_id[q_tail[3:0]] = id;
        q_x[q_tail[3:0]]  = 16'(x);
        q_y[q_tail[3:0]]  = 16'(y);
        q_sc[q_tail[3:0]] = sc;
        s = int'(sc[1:0]);
        span = 32 << s;
        if (x < 320 && y < 240) begin
            for (int dy = 0; dy < span; dy++) begin
                for (int dx = 0; dx < span; dx++) begin
                    if (x + dx < 320 && y + dy < 240) begin
                        ra = {id[3:0], 5'(dy >> s), 5'(dx >> s)};
                        exp_rd_q.push_back(ra);
                        p = pix(ra);
                        if (p != 4'd0) exp_q.push_back({17'((y + dy) * 320 + (x + dx)), p});
                    end
                end
            end
        end
        q_tail = q_tail + 1;
    endtask

    task automatic pulse_start();
        @(posedge sys_clock);
        #1 frame_start = 1'b1;
        @(posedge sys_clock);
        #1 frame_start = 1'b0;
    endtask

    task automatic run_frame(input string name, input int exp_deq, input int exp_rd, input int exp_wr);
        int d0;
        int h0;
        int n;
        d0 = done_cnt;
        h0 = q_head;
        rd_cnt = 0;
        wr_cnt = 0;
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 40000) begin
            @(negedge sys_clock);
            n++;
        end
        if (n >= 40000) chk({name, "_timeout"}, n, 0);
        @(negedge sys_clock);
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_dequeues"}, q_head - h0, exp_deq);
        chk({name, "_reads"}, rd_cnt, exp_rd);
        chk({name, "_writes"}, wr_cnt, exp_wr);
        chk({name, "_exp_rd_left"}, exp_rd_q.size(), 0);
        chk({name, "_exp_wr_left"}, exp_q.size(), 0);
        chk({name, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int d0;
        sys_reset_n = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            q_id[i] = 8'd0; q_x[i] = 16'd0; q_y[i] = 16'd0; q_sc[i] = 8'd0;
        end
        repeat (3) @(negedge sys_clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_deq", dequeue, 0);
        chk("rst_r_en", sprite_r_en, 0);
        chk("rst_w_en", fb_w_en, 0);
        chk("rst_w_addr", fb_w_addr, 0);
        chk("rst_r_addr", sprite_r_addr, 0);
        chk("rst_state", fsm_state, 0);
        #1 sys_reset_n = 1'b1;

        // Empty queue: POP on cycle 1, frame_done on cycle 2, idle on cycle 3.
        pulse_start();
        @(negedge sys_clock);
        chk("empty_c1_busy", busy, 1);
        chk("empty_c1_done", frame_done, 0);
        @(negedge sys_clock);
        chk("empty_c2_busy", busy, 1);
        chk("empty_c2_done", frame_done, 1);
        chk("empty_deq", q_head, 0);
        @(negedge sys_clock);
        chk("empty_c3_busy", busy, 0);
        chk("empty_c3_done", frame_done, 0);

        // Diagonal pattern, s=0 at (1,1): 64 of 1024 pixels are transparent.
        pat_mode = 0;
        add_draw(8'h02, 1, 1, 8'd0);
        run_frame("single_s0", 1, 1024, 960);

        // Solid colour 5, s=1 at origin: 64x64 block.
        pat_mode = 1;
        add_draw(8'h07, 0, 0, 8'd1);
        run_frame("scale_s1", 1, 4096, 4096);

        // Bottom-right clip plus an off-screen entry; upper id bits ignored.
        add_draw(8'hF3, 300, 230, 8'hFC);
        add_draw(8'h01, 400, 10, 8'd0);
        run_frame("clip", 2, 200, 200);

        // Random write backpressure.
        pat_mode = 0;
        bp_en = 1'b1;
        add_draw(8'h05, 100, 50, 8'd0);
        run_frame("backpressure", 1, 1024, 960);
        bp_en = 1'b0;

        // Reset in the middle of a scaled sprite.
        pat_mode = 1;
        add_draw(8'h04, 10, 10, 8'd1);
        d0 = done_cnt;
        pulse_start();
        repeat (300) @(negedge sys_clock);
        chk("mid_busy_before_rst", busy, 1);
        @(posedge sys_clock);
        #1 sys_reset_n = 1'b0;
        @(negedge sys_clock);
        chk("mrst_busy", busy, 0);
        chk("mrst_r_en", sprite_r_en, 0);
        chk("mrst_w_en", fb_w_en, 0);
        chk("mrst_w_addr", fb_w_addr, 0);
        chk("mrst_w_data", fb_w_data, 0);
        chk("mrst_r_addr", sprite_r_addr, 0);
        chk("mrst_deq", dequeue, 0);
        exp_q.delete();
        exp_rd_q.delete();
        repeat (2) @(negedge sys_clock);
        #1 sys_reset_n = 1'b1;
        repeat (10) @(negedge sys_clock);
        chk("mrst_no_done", done_cnt - d0, 0);
        chk("mrst_entry_lost", q_head, q_tail);
        run_frame("after_rst", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
